// File: rtl/mem_port_arbiter_if.sv
// Bundle between the core (fetch + load/store units, plus the memory array)
// and mem_port_arbiter.
//   slave  : the arbiter side (takes requests and read data, drives responses and the memory strobe)
//   master : the core/memory side
// Signals:
//   i_req_*  / i_resp_*  instruction-fetch request and response
//   d_req_*  / d_resp_*  load/store request and response
//   mem_*                single-port memory access (read data returns one cycle after mem_en)
interface mem_port_arbiter_if #(
  parameter int MEM_AW = 16
);
  logic              i_req_valid;
  logic              i_req_ready;
  logic [31:0]       i_req_addr;
  logic              i_resp_valid;
  logic [31:0]       i_resp_data;
  logic              i_resp_err;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [31:0]       d_req_addr;
  logic              d_req_we;
  logic [1:0]        d_req_size;
  logic              d_req_unsigned;
  logic [31:0]       d_req_wdata;
  logic              d_resp_valid;
  logic [31:0]       d_resp_data;
  logic              d_resp_err;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_req_valid, i_req_addr,
    input  d_req_valid, d_req_addr, d_req_we, d_req_size, d_req_unsigned, d_req_wdata,
    input  mem_rdata,
    output i_req_ready, i_resp_valid, i_resp_data, i_resp_err,
    output d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req_valid, i_req_addr,
    output d_req_valid, d_req_addr, d_req_we, d_req_size, d_req_unsigned, d_req_wdata,
    output mem_rdata,
    input  i_req_ready, i_resp_valid, i_resp_data, i_resp_err,
    input  d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port unified memory between instruction fetch
// and load/store. Data has priority; fetch overrides once it has been stalled
// STARVE_LIMIT consecutive cycles. Sub-word stores become word writes with byte
// enables; load data is lane-aligned and sign/zero-extended. One access per cycle,
// response one cycle after acceptance.
// Ports:
//   clk  clock, all state on posedge
//   rst  synchronous reset, active high
//   bus  mem_port_arbiter_if.slave (fetch/data request+response, memory strobe)
module mem_port_arbiter #(
  parameter int MEM_AW       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_e;

  logic [CW-1:0] starve_cnt;
  logic          starved;
  logic          grant_d;
  logic          grant_i;
  logic          d_err;
  logic          i_err;
  logic [1:0]    d_off;

  // In-flight slot: describes the access whose read data arrives next cycle.
  logic          fl_valid;
  port_e         fl_port;
  logic          fl_we;
  logic          fl_uns;
  logic          fl_err;
  logic [1:0]    fl_size;
  logic [1:0]    fl_off;

  logic          resp_v;
  logic          d_rv;
  logic          i_rv;
  logic [31:0]   lane;
  logic [31:0]   load_data;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{bus.d_req_addr[31:MEM_AW+2], bus.i_req_addr[31:MEM_AW+2]};

  assign starved = (starve_cnt == CW'(STARVE_LIMIT));
  assign grant_d = !rst && bus.d_req_valid && !(bus.i_req_valid && starved);
  assign grant_i = !rst && bus.i_req_valid && !grant_d;

  assign bus.d_req_ready = grant_d;
  assign bus.i_req_ready = grant_i;

  assign d_off = bus.d_req_addr[1:0];
  assign i_err = |bus.i_req_addr[1:0];

  always_comb begin
    d_err = 1'b0;
    case (bus.d_req_size)
      2'd0:    d_err = 1'b0;
      2'd1:    d_err = bus.d_req_addr[0];
      2'd2:    d_err = |bus.d_req_addr[1:0];
      default: d_err = 1'b1;
    endcase
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (grant_d && !d_err) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.d_req_addr[MEM_AW+1:2];
      if (bus.d_req_we) begin
        case (bus.d_req_size)
          2'd0: begin
            bus.mem_we    = 4'b0001 << d_off;
            bus.mem_wdata = {4{bus.d_req_wdata[7:0]}};
          end
          2'd1: begin
            bus.mem_we    = 4'b0011 << d_off;
            bus.mem_wdata = {2{bus.d_req_wdata[15:0]}};
          end
          default: begin
            bus.mem_we    = 4'b1111;
            bus.mem_wdata = bus.d_req_wdata;
          end
        endcase
      end
    end else if (grant_i && !i_err) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.i_req_addr[MEM_AW+1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      fl_valid   <= 1'b0;
      fl_port    <= PORT_I;
      fl_we      <= 1'b0;
      fl_uns     <= 1'b0;
      fl_err     <= 1'b0;
      fl_size    <= '0;
      fl_off     <= '0;
    end else begin
      if (bus.i_req_valid && !grant_i) begin
        if (!starved) starve_cnt <= starve_cnt + CW'(1);
      end else begin
        starve_cnt <= '0;
      end
      fl_valid <= grant_d || grant_i;
      fl_port  <= grant_d ? PORT_D : PORT_I;
      fl_we    <= bus.d_req_we;
      fl_uns   <= bus.d_req_unsigned;
      fl_size  <= bus.d_req_size;
      fl_off   <= d_off;
      fl_err   <= grant_d ? d_err : i_err;
    end
  end

  // Gating with rst drops a response that is due in the cycle reset is raised.
  assign resp_v = fl_valid && !rst;
  assign d_rv   = resp_v && (fl_port == PORT_D);
  assign i_rv   = resp_v && (fl_port == PORT_I);

  assign lane = bus.mem_rdata >> {fl_off, 3'b000};

  always_comb begin
    load_data = lane;
    case (fl_size)
      2'd0:    load_data = fl_uns ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'd1:    load_data = fl_uns ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  assign bus.d_resp_valid = d_rv;
  assign bus.d_resp_err   = d_rv && fl_err;
  assign bus.d_resp_data  = (d_rv && !fl_err && !fl_we) ? load_data : '0;
  assign bus.i_resp_valid = i_rv;
  assign bus.i_resp_err   = i_rv && fl_err;
  assign bus.i_resp_data  = (i_rv && !fl_err) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a write-first
// behavioural memory attached to the memory port.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.MEM_AW(16)) b();

  mem_port_arbiter #(.MEM_AW(16), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  logic [31:0] mem [0:65535];
  logic [31:0] wmerge;

  always @(posedge clk) begin
    if (b.mem_en) begin
      wmerge = mem[b.mem_addr];
      for (int i = 0; i < 4; i++)
        if (b.mem_we[i]) wmerge[8*i +: 8] = b.mem_wdata[8*i +: 8];
      mem[b.mem_addr] <= wmerge;
      b.mem_rdata     <= wmerge;
    end
  end

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    b.i_req_valid    = 1'b0;
    b.i_req_addr     = '0;
    b.d_req_valid    = 1'b0;
    b.d_req_addr     = '0;
    b.d_req_we       = 1'b0;
    b.d_req_size     = '0;
    b.d_req_unsigned = 1'b0;
    b.d_req_wdata    = '0;
  endtask

  task automatic dreq(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd);
    b.d_req_valid    = 1'b1;
    b.d_req_we       = we;
    b.d_req_size     = sz;
    b.d_req_unsigned = uns;
    b.d_req_addr     = a;
    b.d_req_wdata    = wd;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // One data access from an idle pipeline: request-cycle checks, then response-cycle checks.
  task automatic d_access(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic exp_en,
                          input logic [3:0] exp_we, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_data, input logic exp_err);
    dreq(we, sz, uns, a, wd);
    mid();
    chk({tag, "_rdy"}, 32'(b.d_req_ready), 1);
    chk({tag, "_en"}, 32'(b.mem_en), 32'(exp_en));
    chk({tag, "_noresp_n"}, 32'(b.d_resp_valid), 0);
    if (exp_en) begin
      chk({tag, "_addr"}, 32'(b.mem_addr), 32'(a[17:2]));
      chk({tag, "_we"}, 32'(b.mem_we), 32'(exp_we));
      if (we) chk({tag, "_wdata"}, b.mem_wdata, exp_wdata);
    end
    next();
    idle();
    mid();
    chk({tag, "_rvalid"}, 32'(b.d_resp_valid), 1);
    chk({tag, "_rdata"}, b.d_resp_data, exp_data);
    chk({tag, "_rerr"}, 32'(b.d_resp_err), 32'(exp_err));
    next();
  endtask

  task automatic i_access(input string tag, input logic [31:0] a, input logic exp_en,
                          input logic [31:0] exp_data, input logic exp_err);
    b.i_req_valid = 1'b1;
    b.i_req_addr  = a;
    mid();
    chk({tag, "_rdy"}, 32'(b.i_req_ready), 1);
    chk({tag, "_en"}, 32'(b.mem_en), 32'(exp_en));
    chk({tag, "_we"}, 32'(b.mem_we), 0);
    next();
    idle();
    mid();
    chk({tag, "_rvalid"}, 32'(b.i_resp_valid), 1);
    chk({tag, "_rdata"}, b.i_resp_data, exp_data);
    chk({tag, "_rerr"}, 32'(b.i_resp_err), 32'(exp_err));
    next();
  endtask

  // D always requests LW @0x200; iv[k] = fetch valid in cycle k, gi[k] = fetch expected granted.
  task automatic run_arb(input string tag, input int n, input logic [15:0] iv, input logic [15:0] gi);
    logic prev_i;
    prev_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      b.i_req_valid = iv[k];
      b.i_req_addr  = 32'h100;
      dreq(1'b0, 2'd2, 1'b0, 32'h200, '0);
      mid();
      chk($sformatf("%s%0d_irdy", tag, k), 32'(b.i_req_ready), 32'(gi[k]));
      chk($sformatf("%s%0d_drdy", tag, k), 32'(b.d_req_ready), 32'(!gi[k]));
      if (k > 0) begin
        chk($sformatf("%s%0d_ivld", tag, k), 32'(b.i_resp_valid), 32'(prev_i));
        chk($sformatf("%s%0d_dvld", tag, k), 32'(b.d_resp_valid), 32'(!prev_i));
        chk($sformatf("%s%0d_data", tag, k), prev_i ? b.i_resp_data : b.d_resp_data,
            prev_i ? 32'h8001_7FF0 : 32'hAB22_5566);
      end
      prev_i = gi[k];
      next();
    end
    idle();
    mid();
    chk({tag, "_last_ivld"}, 32'(b.i_resp_valid), 32'(prev_i));
    chk({tag, "_last_dvld"}, 32'(b.d_resp_valid), 32'(!prev_i));
    next();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] iv;
    logic [15:0] gi;

    // Reset with both requesters asking.
    idle();
    rst = 1'b1;
    b.i_req_valid = 1'b1;
    dreq(1'b0, 2'd2, 1'b0, 32'h100, '0);
    for (int c = 0; c < 2; c++) begin
      mid();
      chk($sformatf("rst%0d_ctl", c),
          32'({b.i_req_ready, b.d_req_ready, b.mem_en, b.mem_we, b.i_resp_valid,
               b.d_resp_valid, b.i_resp_err, b.d_resp_err}), 0);
      chk($sformatf("rst%0d_bus", c), b.mem_wdata | 32'(b.mem_addr) | b.d_resp_data | b.i_resp_data, 0);
      next();
    end
    rst = 1'b0;
    idle();
    mid();
    chk("post_rst_resp", 32'({b.i_resp_valid, b.d_resp_valid}), 0);
    next();

    // Stores and loads.
    d_access("sw100", 1'b1, 2'd2, 1'b0, 32'h100, 32'h8001_7FF0, 1'b1, 4'hF, 32'h8001_7FF0, 0, 1'b0);
    d_access("sw200", 1'b1, 2'd2, 1'b0, 32'h200, 32'h1122_3344, 1'b1, 4'hF, 32'h1122_3344, 0, 1'b0);
    d_access("lh102", 1'b0, 2'd1, 1'b0, 32'h102, 0, 1'b1, 4'h0, 0, 32'hFFFF_8001, 1'b0);
    d_access("lhu102", 1'b0, 2'd1, 1'b1, 32'h102, 0, 1'b1, 4'h0, 0, 32'h0000_8001, 1'b0);
    d_access("lh100", 1'b0, 2'd1, 1'b0, 32'h100, 0, 1'b1, 4'h0, 0, 32'h0000_7FF0, 1'b0);
    d_access("lb103", 1'b0, 2'd0, 1'b0, 32'h103, 0, 1'b1, 4'h0, 0, 32'hFFFF_FF80, 1'b0);
    d_access("lbu100", 1'b0, 2'd0, 1'b1, 32'h100, 0, 1'b1, 4'h0, 0, 32'h0000_00F0, 1'b0);
    d_access("sb203", 1'b1, 2'd0, 1'b0, 32'h203, 32'h1234_56AB, 1'b1, 4'b1000, 32'hABAB_ABAB, 0, 1'b0);
    d_access("lw200a", 1'b0, 2'd2, 1'b0, 32'h200, 0, 1'b1, 4'h0, 0, 32'hAB22_3344, 1'b0);
    d_access("sh200", 1'b1, 2'd1, 1'b0, 32'h200, 32'hFFFF_5566, 1'b1, 4'b0011, 32'h5566_5566, 0, 1'b0);
    d_access("lw200b", 1'b0, 2'd2, 1'b0, 32'h200, 0, 1'b1, 4'h0, 0, 32'hAB22_5566, 1'b0);

    // Alignment and size errors.
    d_access("lh101", 1'b0, 2'd1, 1'b0, 32'h101, 0, 1'b0, 4'h0, 0, 0, 1'b1);
    d_access("lw202", 1'b0, 2'd2, 1'b0, 32'h202, 0, 1'b0, 4'h0, 0, 0, 1'b1);
    d_access("sz3", 1'b1, 2'd3, 1'b0, 32'h200, 32'hDEAD_BEEF, 1'b0, 4'h0, 0, 0, 1'b1);

    // Fetch.
    i_access("if102", 32'h102, 1'b0, 0, 1'b1);
    i_access("if100", 32'h100, 1'b1, 32'h8001_7FF0, 1'b0);

    // Starvation guard: continuous contention, then a fetch gap that clears the count.
    iv = 16'h03FF;
    gi = 16'h0210;
    run_arb("arbA", 10, iv, gi);
    iv = 16'h00FB;
    gi = 16'h0080;
    run_arb("arbB", 8, iv, gi);

    // Reset raised the cycle after a load is accepted.
    dreq(1'b0, 2'd2, 1'b0, 32'h200, '0);
    mid();
    chk("mf_rdy", 32'(b.d_req_ready), 1);
    next();
    idle();
    rst = 1'b1;
    mid();
    chk("mf_drop", 32'(b.d_resp_valid), 0);
    next();
    rst = 1'b0;
    mid();
    chk("mf_after", 32'({b.d_resp_valid, b.i_resp_valid}), 0);
    next();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
